mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_WORDS, default 256, number of 32-bit words in the downstream single-port RAM.
REQ-002 Parameter: ADDR_SHIFT, default 2, right-shift applied to master byte addresses to form the RAM word index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m_req_i / m_gnt_o / m_rvalid_o  in/out/out  [1:0] each  per-master request, same-cycle grant, response valid (index 0 = instr, 1 = data).
REQ-006 m_addr_i / m_wdata_i  input  2x32  per-master byte address, write data.
REQ-007 m_we_i  input  [1:0]  per-master write enable.
REQ-008 m_rdata_o  output  2x32  per-master read data, valid only with m_rvalid_o.
REQ-009 m_err_o  output  [1:0]  per-master out-of-range error, valid only with m_rvalid_o.
REQ-010 ram_req_o / ram_gnt_i / ram_rvalid_i  out/in/in  1 each  downstream RAM handshake.
REQ-011 ram_addr_o / ram_wdata_o / ram_rdata_i  out/out/in  32 each  word index, write data, combinational read data.
REQ-012 ram_we_o  output  1  downstream write enable.

Function
REQ-013 Grant is combinational: at most one m_gnt_o bit high per cycle; granted master's transfer is accepted that cycle.
REQ-014 Single requester: granted the same cycle, provided the RAM grants (in-range) or address is out of range.
REQ-015 Both requesting: round-robin; master not granted most recently wins; loser holds m_req_i and is granted next cycle at the latest.
REQ-016 After reset, the round-robin pointer favours master 0 (instr).
REQ-017 Word index = m_addr_i >> ADDR_SHIFT; in range iff index < MEM_WORDS.
REQ-018 In-range selected request: ram_req_o=1, ram_addr_o=index, ram_we_o/ram_wdata_o from the selected master; m_gnt_o = ram_gnt_i.
REQ-019 Out-of-range: ram_req_o=0, ram_we_o=0 (no RAM write); master granted locally; response has m_err_o=1, m_rdata_o=0.
REQ-020 ram_we_o is never high without ram_req_o high in the same cycle.
REQ-021 In-range read: ram_rdata_i captured in the grant cycle, presented on the owner's m_rdata_o the following cycle.
REQ-022 Writes: m_rdata_o=0, m_err_o=0 in the response cycle.
REQ-023 Response latency exactly 1 cycle: m_rvalid_o of the granted master high in cycle N+1 for grant in cycle N, single-cycle pulse.
REQ-024 Back-to-back grants allowed every cycle; a response in N+1 and a new grant in N+1 coexist.
REQ-025 m_rvalid_o is routed by an internal owner register, never by ram_rvalid_i alone; in-range ram_rvalid_i arriving without a pending owner is ignored.
REQ-026 Non-selected master: m_gnt_o=0, m_rvalid_o=0, m_rdata_o=0, m_err_o=0.
REQ-027 Pointer updates only on an actual grant; a withheld RAM grant does not rotate priority.

Reset
REQ-028 While rst=1: all m_gnt_o, m_rvalid_o, m_err_o, ram_req_o, ram_we_o are 0; m_rdata_o=0; pending response and owner cleared; pointer set per REQ-016.
REQ-029 Reset asserted in a grant cycle: that transfer's response is dropped; no m_rvalid_o in the following cycle.

Structure
REQ-030 Package mem_arb_pkg holds master_e enum (M_INSTR=0, M_DATA=1), default MEM_WORDS and ADDR_SHIFT constants.
REQ-031 Two-way round-robin arbitration lives in sub-module rr_arb2 (req[1:0], advance -> gnt[1:0], pointer register); response capture and routing stay in mem_arbiter.

Verification
REQ-032 Instr-only read addr 0x10, ram_rdata_i=0xDEADBEEF -> gnt cycle N, m_rvalid_o[0] and m_rdata_o[0]=0xDEADBEEF in N+1, ram_addr_o=4.
REQ-033 Both masters request every cycle for 4 cycles after reset -> grants alternate instr, data, instr, data; each rvalid one cycle after its grant.
REQ-034 Data write addr 0x0 wdata 0x1 -> ram_we_o=1, ram_addr_o=0, ram_wdata_o=0x1; next cycle m_rvalid_o[1]=1, m_rdata_o[1]=0, m_err_o[1]=0.
REQ-035 Data read addr 0x400 (index 256) -> ram_req_o=0, gnt same cycle, next cycle m_err_o[1]=1, m_rdata_o[1]=0.
REQ-036 ram_gnt_i=0 for 3 cycles with both masters requesting -> no m_gnt_o, pointer unchanged; on ram_gnt_i=1 instr granted first.
REQ-037 rst=1 in the grant cycle of an instr read -> no m_rvalid_o next cycle; after rst release instr has priority.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-master memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    M_INSTR = 1'b0,
    M_DATA  = 1'b1
  } master_e;

  localparam int unsigned MEM_WORDS_DEF  = 256;
  localparam int unsigned ADDR_SHIFT_DEF = 2;

  typedef struct packed {
    logic        valid;
    master_e     owner;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector; the pointer names the master favoured on a tie
// and only moves when the caller reports that the selected transfer was accepted.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  master_e ptr_q, ptr_d;
  master_e win;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win   = ptr_q;
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (req_i == 2'b01)      win = M_INSTR;
    else if (req_i == 2'b10) win = M_DATA;
    if (|req_i) begin
      gnt_o = (win == M_DATA) ? 2'b10 : 2'b01;
      if (advance_i) ptr_d = (win == M_INSTR) ? M_DATA : M_INSTR;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= M_INSTR;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data masters onto one single-port RAM with a fixed
// one-cycle response; out-of-range accesses are answered locally with an error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEF,
  parameter int unsigned ADDR_SHIFT = ADDR_SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       m_req_i,
  output logic [1:0]       m_gnt_o,
  output logic [1:0]       m_rvalid_o,
  input  logic [1:0][31:0] m_addr_i,
  input  logic [1:0][31:0] m_wdata_i,
  input  logic [1:0]       m_we_i,
  output logic [1:0][31:0] m_rdata_o,
  output logic [1:0]       m_err_o,
  output logic             ram_req_o,
  input  logic             ram_gnt_i,
  input  logic             ram_rvalid_i,
  output logic [31:0]      ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i,
  output logic             ram_we_o
);

  logic [1:0]  req_live;
  logic [1:0]  sel;
  logic        sel_bit;
  logic [31:0] word_idx;
  logic        in_range;
  logic        xfer;
  rsp_t        rsp_q, rsp_d;
  logic        rsp_live;
  logic        own_data;

  // Responses are routed solely by the owner register; the RAM's own valid is not needed.
  logic unused_ram_rvalid;
  assign unused_ram_rvalid = ram_rvalid_i;

  assign req_live = rst ? 2'b00 : m_req_i;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_live),
    .advance_i(xfer),
    .gnt_o    (sel)
  );

  assign sel_bit  = sel[1];
  assign word_idx = m_addr_i[sel_bit] >> ADDR_SHIFT;
  assign in_range = word_idx < 32'(MEM_WORDS);

  // A selected request completes when the RAM accepts it or when it never reaches the RAM.
  assign xfer        = (|sel) && (!in_range || ram_gnt_i);
  assign m_gnt_o     = xfer ? sel : 2'b00;
  assign ram_req_o   = (|sel) && in_range;
  assign ram_we_o    = ram_req_o && m_we_i[sel_bit];
  assign ram_addr_o  = ram_req_o ? word_idx : 32'd0;
  assign ram_wdata_o = ram_req_o ? m_wdata_i[sel_bit] : 32'd0;

  always_comb begin
    rsp_d = '0;
    if (xfer) begin
      rsp_d.valid = 1'b1;
      rsp_d.owner = sel_bit ? M_DATA : M_INSTR;
      rsp_d.err   = !in_range;
      rsp_d.rdata = (in_range && !m_we_i[sel_bit]) ? ram_rdata_i : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rsp_q <= '0;
    else     rsp_q <= rsp_d;
  end

  assign rsp_live     = rsp_q.valid && !rst;
  assign own_data     = (rsp_q.owner == M_DATA);
  assign m_rvalid_o   = {rsp_live && own_data, rsp_live && !own_data};
  assign m_err_o      = m_rvalid_o & {2{rsp_q.err}};
  assign m_rdata_o[0] = m_rvalid_o[0] ? rsp_q.rdata : 32'd0;
  assign m_rdata_o[1] = m_rvalid_o[1] ? rsp_q.rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each vector is driven mid-cycle and its
// grant-side outputs checked before the edge, responses checked the cycle after.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       m_req_i, m_gnt_o, m_rvalid_o, m_we_i, m_err_o;
  logic [1:0][31:0] m_addr_i, m_wdata_i, m_rdata_o;
  logic             ram_req_o, ram_gnt_i, ram_rvalid_i, ram_we_o;
  logic [31:0]      ram_addr_o, ram_wdata_o, ram_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_gnt_o     (m_gnt_o),
    .m_rvalid_o  (m_rvalid_o),
    .m_addr_i    (m_addr_i),
    .m_wdata_i   (m_wdata_i),
    .m_we_i      (m_we_i),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .ram_req_o   (ram_req_o),
    .ram_gnt_i   (ram_gnt_i),
    .ram_rvalid_i(ram_rvalid_i),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_we_o    (ram_we_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic gnt, input logic [31:0] rdata);
    m_req_i     = req;
    m_we_i      = we;
    m_addr_i[0] = a0;
    m_addr_i[1] = a1;
    m_wdata_i[0] = w0;
    m_wdata_i[1] = w1;
    ram_gnt_i   = gnt;
    ram_rdata_i = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] exp_addr[4] = '{32'd8, 32'd12, 32'd8, 32'd12};

  initial begin
    rst = 1'b1;
    ram_rvalid_i = 1'b0;
    // Reset held with an in-range request pending: nothing may leave the block.
    drive(2'b11, 2'b11, 32'h10, 32'h10, 32'h5, 32'h6, 1'b1, 32'hAAAA_5555);
    check("rst_gnt", 32'(m_gnt_o), 32'd0);
    check("rst_ram_req", 32'(ram_req_o), 32'd0);
    check("rst_ram_we", 32'(ram_we_o), 32'd0);
    tick();
    check("rst_rvalid", 32'(m_rvalid_o), 32'd0);
    check("rst_err", 32'(m_err_o), 32'd0);
    check("rst_rdata0", m_rdata_o[0], 32'd0);
    rst = 1'b0;

    // Both masters every cycle: strict alternation starting with instr.
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, 2'b00, 32'h20, 32'h30, 32'h0, 32'h0, 1'b1, 32'h100 + 32'(k));
      check($sformatf("rr_gnt%0d", k), 32'(m_gnt_o), 32'(exp_gnt[k]));
      check($sformatf("rr_addr%0d", k), ram_addr_o, exp_addr[k]);
      if (k > 0) begin
        check($sformatf("rr_rvalid%0d", k - 1), 32'(m_rvalid_o), 32'(exp_gnt[k - 1]));
        check($sformatf("rr_rdata%0d", k - 1), m_rdata_o[exp_gnt[k - 1][1]], 32'h100 + 32'(k - 1));
      end
      tick();
    end

    // RAM withholds grant: no master granted, priority stays with instr.
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b00, 32'h20, 32'h30, 32'h0, 32'h0, 1'b0, 32'h0);
      check($sformatf("stall_gnt%0d", k), 32'(m_gnt_o), 32'd0);
      check($sformatf("stall_addr%0d", k), ram_addr_o, 32'd8);
      if (k == 0) begin
        check("rr_rvalid3", 32'(m_rvalid_o), 32'b10);
        check("rr_rdata3", m_rdata_o[1], 32'h103);
      end else begin
        check($sformatf("stall_rvalid%0d", k), 32'(m_rvalid_o), 32'd0);
      end
      tick();
    end
    drive(2'b11, 2'b00, 32'h20, 32'h30, 32'h0, 32'h0, 1'b1, 32'h77);
    check("unstall_gnt", 32'(m_gnt_o), 32'b01);
    tick();

    // Instr-only read from 0x10; data is favoured now but does not request.
    drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("unstall_rvalid", 32'(m_rvalid_o), 32'b01);
    check("unstall_rdata", m_rdata_o[0], 32'h77);
    check("ird_gnt", 32'(m_gnt_o), 32'b01);
    check("ird_addr", ram_addr_o, 32'd4);
    check("ird_we", 32'(ram_we_o), 32'd0);
    tick();

    // Data write to 0x0; read data on the RAM bus must not leak into the response.
    drive(2'b10, 2'b10, 32'h0, 32'h0, 32'h0, 32'h1, 1'b1, 32'hFFFF_FFFF);
    check("ird_rvalid", 32'(m_rvalid_o), 32'b01);
    check("ird_rdata", m_rdata_o[0], 32'hDEAD_BEEF);
    check("ird_rdata1", m_rdata_o[1], 32'd0);
    check("dwr_gnt", 32'(m_gnt_o), 32'b10);
    check("dwr_we", 32'(ram_we_o), 32'd1);
    check("dwr_addr", ram_addr_o, 32'd0);
    check("dwr_wdata", ram_wdata_o, 32'd1);
    tick();

    // Data read at index 256: local grant even with the RAM refusing.
    drive(2'b10, 2'b00, 32'h0, 32'h400, 32'h0, 32'h0, 1'b0, 32'h1234_5678);
    check("dwr_rvalid", 32'(m_rvalid_o), 32'b10);
    check("dwr_rdata", m_rdata_o[1], 32'd0);
    check("dwr_err", 32'(m_err_o), 32'd0);
    check("oor_ram_req", 32'(ram_req_o), 32'd0);
    check("oor_gnt", 32'(m_gnt_o), 32'b10);
    tick();

    // Out-of-range instr write must never reach the RAM.
    drive(2'b01, 2'b01, 32'h1000, 32'h0, 32'hCAFE, 32'h0, 1'b1, 32'h1234_5678);
    check("oor_rvalid", 32'(m_rvalid_o), 32'b10);
    check("oor_err", 32'(m_err_o), 32'b10);
    check("oor_rdata", m_rdata_o[1], 32'd0);
    check("oorw_gnt", 32'(m_gnt_o), 32'b01);
    check("oorw_ram_we", 32'(ram_we_o), 32'd0);
    tick();
    check("oorw_err", 32'(m_err_o), 32'b01);

    // Reset coincides with an instr read: the response is dropped.
    rst = 1'b1;
    drive(2'b01, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 32'h5A5A_5A5A);
    check("rstg_rvalid", 32'(m_rvalid_o), 32'd0);
    check("rstg_gnt", 32'(m_gnt_o), 32'd0);
    tick();
    rst = 1'b0;
    ram_rvalid_i = 1'b1;
    drive(2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 1'b1, 32'h5A5A_5A5A);
    check("rstg_rvalid_next", 32'(m_rvalid_o), 32'd0);
    tick();
    check("stray_rvalid", 32'(m_rvalid_o), 32'd0);
    ram_rvalid_i = 1'b0;
    drive(2'b11, 2'b00, 32'h10, 32'h14, 32'h0, 32'h0, 1'b1, 32'h0);
    check("post_rst_prio", 32'(m_gnt_o), 32'b01);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
